// File: rtl/divider_pkg.sv
// divider_pkg: FSM state encoding and iteration-counter sizing for the sequential divider.
package divider_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIVIDE = 3'd2,
    FIXUP  = 3'd3,
    DONE   = 3'd4
  } state_e;
  localparam int BITS_DEF = 4;
  localparam int CNT_W = $clog2(BITS_DEF);
  function automatic int cnt_w(input int bits);
    return bits > 1 ? $clog2(bits) : 1;
  endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration on {R,Q}.
module divider_step #(
  parameter int BITS = 4
) (
  input  logic [BITS:0]   r_i,
  input  logic [BITS-1:0] q_i,
  input  logic [BITS-1:0] d_i,
  output logic [BITS:0]   r_o,
  output logic [BITS-1:0] q_o
);
  logic [BITS:0]   rs, diff;
  logic [BITS-1:0] qs;
  assign {rs, qs} = {r_i, q_i} << 1;
  assign diff = rs - {1'b0, d_i};
  // a clear sign bit means the divisor fit: keep the difference and retire a 1
  assign r_o = diff[BITS] ? rs : diff;
  assign q_o = qs | {{(BITS-1){1'b0}}, ~diff[BITS]};
endmodule

// File: rtl/divider.sv
// divider: sequential restoring divider, one quotient bit per clock, start/finished handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands with a FIXUP sign-correction state.
module divider
  import divider_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [BITS-1:0] i_dividend,
  input  logic [BITS-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_finished,
  output logic [BITS-1:0] o_quotient,
  output logic [BITS-1:0] o_remainder,
  output logic            o_div_by_zero
);
  localparam int CW = cnt_w(BITS);
  state_e          state_q, state_d;
  logic [BITS-1:0] dvd_q, dvd_d, dvs_q, dvs_d, q_q, q_d, quo_q, quo_d, rem_q, rem_d;
  logic [BITS-1:0] mag_a, mag_b, q_n;
  logic [BITS:0]   r_q, r_d, r_n;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dbz_q, dbz_d, fin_q, fin_d, zero;
`ifdef DIVIDER_SIGNED_EN
  assign mag_a = dvd_q[BITS-1] ? -dvd_q : dvd_q;
  assign mag_b = dvs_q[BITS-1] ? -dvs_q : dvs_q;
`else
  assign mag_a = dvd_q;
  assign mag_b = dvs_q;
`endif
  assign zero = dvs_q == '0;
  divider_step #(.BITS(BITS)) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(mag_b),
    .r_o(r_n),
    .q_o(q_n)
  );
  always_comb begin
    state_d = state_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    r_d = r_q;
    q_d = q_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    fin_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        dvd_d = i_start ? i_dividend : dvd_q;
        dvs_d = i_start ? i_divisor : dvs_q;
        state_d = i_start ? LOAD : IDLE;
      end
      LOAD: begin
        quo_d = '0;
        rem_d = '0;
        dbz_d = 1'b0;
        cnt_d = CW'(BITS - 1);
        // divide-by-zero preloads its fixed result and bypasses the iterations
        r_d = zero ? {1'b0, dvd_q} : '0;
        q_d = zero ? '1 : mag_a;
        state_d = zero ? DONE : DIVIDE;
      end
      DIVIDE: begin
        r_d = r_n;
        q_d = q_n;
        cnt_d = cnt_q - 1'b1;
`ifdef DIVIDER_SIGNED_EN
        state_d = cnt_q == '0 ? FIXUP : DIVIDE;
`else
        state_d = cnt_q == '0 ? DONE : DIVIDE;
`endif
      end
`ifdef DIVIDER_SIGNED_EN
      FIXUP: begin
        q_d = (dvd_q[BITS-1] ^ dvs_q[BITS-1]) ? -q_q : q_q;
        r_d = dvd_q[BITS-1] ? -r_q : r_q;
        state_d = DONE;
      end
`endif
      DONE: begin
        quo_d = q_q;
        rem_d = r_q[BITS-1:0];
        dbz_d = zero;
        fin_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      r_q <= r_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
      fin_q <= fin_d;
    end
  end
  assign o_busy = state_q != IDLE;
  assign o_finished = fin_q;
  assign o_quotient = quo_q;
  assign o_remainder = rem_q;
  assign o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider (BITS=4) against an arithmetic reference model.
module tb_divider;
`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] dvd = '0, dvs = '0, q, r;
  logic       busy, fin, dbz;
  int         errors = 0, checks = 0;
  divider dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_start(start),
    .i_dividend(dvd),
    .i_divisor(dvs),
    .o_busy(busy),
    .o_finished(fin),
    .o_quotient(q),
    .o_remainder(r),
    .o_div_by_zero(dbz)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic void ref_div(input logic [3:0] a, b, output logic [3:0] eq, er, output logic ez);
    ez = b == 4'd0;
    eq = 4'hf;
    er = a;
`ifdef DIVIDER_SIGNED_EN
    if (!ez) begin
      eq = 4'(int'($signed(a)) / int'($signed(b)));
      er = 4'(int'($signed(a)) % int'($signed(b)));
    end
`else
    if (!ez) begin
      eq = a / b;
      er = a % b;
    end
`endif
  endfunction
  // one accepted start, then scramble operands and count edges until o_finished
  task automatic op(input logic [3:0] a, b, output int lat);
    @(negedge clk);
    start = 1'b1;
    dvd = a;
    dvs = b;
    @(posedge clk);
    #1 start = 1'b0;
    dvd = 4'($urandom);
    dvs = 4'($urandom);
    lat = 0;
    while (fin !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if ({busy, fin, dbz, q, r} !== 11'd0) begin
      errors++;
      $display("FAIL reset: busy=%b fin=%b dbz=%b q=%0d r=%0d, want all 0", busy, fin, dbz, q, r);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_vectors();
    logic [3:0] tv [8][4];
    int n, lat;
`ifdef DIVIDER_SIGNED_EN
    tv = '{'{4'd9, 4'd2, 4'd13, 4'd15}, '{4'd7, 4'd14, 4'd13, 4'd1}, '{4'd8, 4'd15, 4'd8, 4'd0},
           '{4'd6, 4'd3, 4'd2, 4'd0}, '{4'd9, 4'd9, 4'd1, 4'd0}, '{4'd5, 4'd13, 4'd15, 4'd2},
           '{4'd7, 4'd1, 4'd7, 4'd0}, '{4'd12, 4'd5, 4'd0, 4'd12}};
    n = 8;
`else
    tv = '{'{4'd13, 4'd4, 4'd3, 4'd1}, '{4'd11, 4'd13, 4'd0, 4'd11}, '{4'd15, 4'd1, 4'd15, 4'd0},
           '{4'd15, 4'd15, 4'd1, 4'd0}, '{4'd8, 4'd2, 4'd4, 4'd0}, '{4'd0, 4'd7, 4'd0, 4'd0},
           '{4'd14, 4'd3, 4'd4, 4'd2}, '{4'd7, 4'd9, 4'd0, 4'd7}};
    n = 8;
`endif
    for (int i = 0; i < n; i++) begin
      op(tv[i][0], tv[i][1], lat);
      checks++;
      if (lat !== LAT || q !== tv[i][2] || r !== tv[i][3] || dbz !== 1'b0) begin
        errors++;
        $display("FAIL vector %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b, want lat=%0d q=%0d r=%0d dbz=0",
                 tv[i][0], tv[i][1], lat, q, r, dbz, LAT, tv[i][2], tv[i][3]);
      end
    end
  endtask
  task automatic test_hold();
    logic [3:0] eq, er;
    logic ez;
    int lat;
    op(4'd13, 4'd4, lat);
    ref_div(4'd13, 4'd4, eq, er, ez);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (fin !== 1'b0 || busy !== 1'b0 || q !== eq || r !== er) begin
      errors++;
      $display("FAIL hold: fin=%b busy=%b q=%0d r=%0d, want fin=0 busy=0 q=%0d r=%0d", fin, busy, q, r, eq, er);
    end
  endtask
  task automatic test_div_zero();
    logic [3:0] eq, er;
    logic ez;
    int lat;
    op(4'd9, 4'd0, lat);
    checks++;
    if (lat !== 2 || q !== 4'd15 || r !== 4'd9 || dbz !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: lat=%0d q=%0d r=%0d dbz=%b, want lat=2 q=15 r=9 dbz=1", lat, q, r, dbz);
    end
    op(4'd8, 4'd2, lat);
    ref_div(4'd8, 4'd2, eq, er, ez);
    checks++;
    if (lat !== LAT || q !== eq || r !== er || dbz !== 1'b0) begin
      errors++;
      $display("FAIL after_zero: lat=%0d q=%0d r=%0d dbz=%b, want lat=%0d q=%0d r=%0d dbz=0", lat, q, r, dbz, LAT, eq, er);
    end
  endtask
  task automatic test_reset_mid();
    logic [3:0] eq, er;
    logic ez;
    int lat, seen;
    @(negedge clk);
    start = 1'b1;
    dvd = 4'd14;
    dvs = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({busy, fin, dbz, q, r} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b fin=%b dbz=%b q=%0d r=%0d, want all 0", busy, fin, dbz, q, r);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 seen += int'(fin);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: finished pulses=%0d, want 0", seen);
    end
    op(4'd14, 4'd3, lat);
    ref_div(4'd14, 4'd3, eq, er, ez);
    checks++;
    if (lat !== LAT || q !== eq || r !== er) begin
      errors++;
      $display("FAIL reset_mid_rerun: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d", lat, q, r, LAT, eq, er);
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] eq, er;
    logic ez;
    int n;
    @(negedge clk);
    start = 1'b1;
    dvd = 4'd13;
    dvs = 4'd4;
    @(posedge clk);
    #1 dvd = 4'd14;
    dvs = 4'd5;
    n = 0;
    while (fin !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1 n++;
    end
    ref_div(4'd13, 4'd4, eq, er, ez);
    checks++;
    if (n !== LAT || q !== eq || r !== er) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d", n, q, r, LAT, eq, er);
    end
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (fin !== 1'b1 && n < 30);
    @(negedge clk) start = 1'b0;
    ref_div(4'd14, 4'd5, eq, er, ez);
    checks++;
    if (n !== LAT + 1 || q !== eq || r !== er) begin
      errors++;
      $display("FAIL b2b_second: period=%0d q=%0d r=%0d, want period=%0d q=%0d r=%0d", n, q, r, LAT + 1, eq, er);
    end
  endtask
  task automatic test_sweep();
    int idx[256];
    int j, t, lat, exp_lat;
    logic [3:0] a, b, eq, er;
    logic ez;
    for (int i = 0; i < 256; i++) idx[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = idx[i];
      idx[i] = idx[j];
      idx[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      a = 4'(idx[i] >> 4);
      b = 4'(idx[i]);
      op(a, b, lat);
      ref_div(a, b, eq, er, ez);
      exp_lat = ez ? 2 : LAT;
      checks++;
      if (lat !== exp_lat || q !== eq || r !== er || dbz !== ez) begin
        errors++;
        $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b, want lat=%0d q=%0d r=%0d dbz=%b",
                 a, b, lat, q, r, dbz, exp_lat, eq, er, ez);
      end
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
